// File: rtl/bundle_queue_pkg.sv
// Shared types for the front-end queues: payload bundles and the unsigned-min helper.
package bundle_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fet_bundle_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/queue_rotator.sv
// N-way circular selector: output slot k = input entry (base + k) mod DEPTH.
module queue_rotator #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned N     = 4
) (
    input  logic [$clog2(DEPTH)-1:0] base,
    input  logic [DEPTH*WIDTH-1:0]   din,
    output logic [N*WIDTH-1:0]       dout
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        dout = '0;
        idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // pointer arithmetic wraps naturally because DEPTH is a power of two
            idx = base + PW'(k);
            dout[k*WIDTH +: WIDTH] = din[32'(idx)*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/bundle_queue.sv
// Multi-port in-order elastic queue; BUNDLE_QUEUE_BYPASS_EN enables same-cycle
// presentation of accepted inputs when the queue is empty.
module bundle_queue
    import bundle_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IN    = 4,
    parameter int unsigned OUT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [$clog2(IN+1)-1:0]    inum,
    input  logic [IN*WIDTH-1:0]        ibits,
    output logic [$clog2(IN+1)-1:0]    iacc,
    output logic [$clog2(OUT+1)-1:0]   onum,
    output logic [OUT*WIDTH-1:0]       obits,
    input  logic [$clog2(OUT+1)-1:0]   otake,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned IW = $clog2(IN+1);
    localparam int unsigned OW = $clog2(OUT+1);

    typedef logic [PW-1:0] qptr_t;

    logic [DEPTH*WIDTH-1:0] mem;
    qptr_t                  hd;
    qptr_t                  tl;
    logic [CW-1:0]          cnt;

    logic [OUT*WIDTH-1:0]   rd_bits;
    logic [OUT*WIDTH-1:0]   byp_bits;
    logic [DEPTH*WIDTH-1:0] wr_src;
    logic [DEPTH*WIDTH-1:0] wr_bits;
    logic [DEPTH-1:0]       wen;
    qptr_t                  wr_base;
    qptr_t                  off;
    logic                   byp;
    int unsigned            acc_n;
    int unsigned            out_n;
    int unsigned            take_n;
    int unsigned            skip_n;
    int unsigned            wr_n;

    assign count = cnt;

    queue_rotator #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .N     (OUT)
    ) u_rd_rot (
        .base (hd),
        .din  (mem),
        .dout (rd_bits)
    );

    // Write side reuses the rotator: base = -tl maps entry e to source slot e - tl.
    queue_rotator #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .N     (DEPTH)
    ) u_wr_rot (
        .base (wr_base),
        .din  (wr_src),
        .dout (wr_bits)
    );

    always_comb begin
        acc_n = flush ? 0 : min_u(32'(inum), DEPTH - 32'(cnt));
`ifdef BUNDLE_QUEUE_BYPASS_EN
        byp = (cnt == '0) && !flush;
`else
        byp = 1'b0;
`endif
        out_n    = byp ? min_u(acc_n, OUT) : min_u(32'(cnt), OUT);
        take_n   = flush ? 0 : min_u(32'(otake), out_n);
        // bypassed entries consumed this cycle never reach storage
        skip_n   = byp ? take_n : 0;
        wr_n     = acc_n - skip_n;
        iacc     = IW'(acc_n);
        onum     = OW'(out_n);
        byp_bits = (OUT*WIDTH)'(ibits);
        wr_src   = (DEPTH*WIDTH)'(ibits >> (skip_n*WIDTH));
        wr_base  = qptr_t'(0) - tl;

        obits = '0;
        for (int unsigned k = 0; k < OUT; k++) begin
            if (k < out_n) begin
                obits[k*WIDTH +: WIDTH] = byp ? byp_bits[k*WIDTH +: WIDTH]
                                              : rd_bits[k*WIDTH +: WIDTH];
            end
        end

        wen = '0;
        off = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            off    = qptr_t'(e) - tl;
            wen[e] = (32'(off) < wr_n);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else if (flush) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (wen[e]) begin
                    mem[e*WIDTH +: WIDTH] <= wr_bits[e*WIDTH +: WIDTH];
                end
            end
            hd  <= hd + qptr_t'(take_n - skip_n);
            tl  <= tl + qptr_t'(wr_n);
            cnt <= CW'(32'(cnt) + wr_n - (take_n - skip_n));
        end
    end

endmodule

// File: doc/bundle_queue.md
# bundle_queue

Parametrised multi-port in-order queue carrying packed pipeline bundles between front-end stages, for example fetch to decode with `fet_bundle_t` as the payload. Each cycle it accepts up to `IN` entries and presents up to `OUT` entries. Occupancy-based back-pressure, dequeue counts and a single-cycle flush let it generalise the fixed one-wide stage registers used today. It sits wherever a stage boundary needs elastic buffering with superscalar width.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits (instantiated as `$bits(fet_bundle_t)` etc.).
- `DEPTH`, default 16: entry count; power of two, ≥ max(`IN`,`OUT`).
- `IN`, default 4: enqueue ports.
- `OUT`, default 4: dequeue ports.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all contents.
- `inum`  in  $clog2(IN+1)  number of offered entries, packed from slot 0.
- `ibits`  in  IN*WIDTH  offered payloads; slot k at [k*WIDTH +: WIDTH].
- `iacc`  out  $clog2(IN+1)  number of offered entries accepted this cycle.
- `onum`  out  $clog2(OUT+1)  number of valid output entries, packed from slot 0.
- `obits`  out  OUT*WIDTH  output payloads, oldest in slot 0.
- `otake`  in  $clog2(OUT+1)  number of output entries consumed this cycle.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is a circular array with head pointer `hd`, tail pointer `tl` (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and an explicit `count` register. Full and empty are derived from `count`, never from pointer equality.
- `free = DEPTH - count`. This uses the pre-edge count; a same-cycle dequeue gives no credit to enqueue.
- `iacc = flush ? 0 : min(inum, free)`. The producer must drop exactly the first `iacc` slots and re-offer the rest, in order, next cycle.
- Enqueue writes `ibits` slots 0..iacc-1 to entries `tl`..`tl+iacc-1` (mod DEPTH). Then `tl += iacc`.
- Output: `onum = min(count, OUT)`. Slot k = entry `hd+k` (mod DEPTH). Slots ≥ `onum` are driven 0.
- `take = flush ? 0 : min(otake, onum)`; an `otake` above `onum` is clipped, not an error. Then `hd += take`.
- Next-cycle `count = count + iacc - take`.
- Flush: `hd`, `tl` and `count` become 0 next cycle. Flush wins over simultaneous enqueue and dequeue. Storage contents are left as they are.
- Inputs `inum` > `IN` or `otake` > `OUT` are illegal. The bench asserts they never occur.

## Timing
- Reset (async assert, sync release by the system): `hd`=`tl`=`count`=0 and storage=0, so `onum`=0, `obits`=0 and `count`=0. `iacc` reflects `min(inum, DEPTH)` as soon as `rst` is high.
- Enqueue-to-output latency is 1 cycle without bypass: an entry accepted in cycle n is visible in `obits` at n+1.
- `iacc`, `onum` and `obits` are combinational from registered state plus `inum`/`flush`. There is no path from `otake` to `iacc`.
- Wrap-around: an enqueue or dequeue group that spans entry DEPTH-1 → 0 is handled in one cycle.
- Full (`count`=DEPTH): `iacc`=0; dequeue proceeds normally.
- Empty: `onum`=0, and `otake` is ignored.
- Reset mid-operation discards all contents immediately, regardless of in-flight handshakes.

## Configuration
- `BUNDLE_QUEUE_BYPASS_EN` defined: when `count`=0 and `flush`=0, accepted input slots are also presented same-cycle.
  - `onum = min(iacc, OUT)`, and `obits` slot k = `ibits` slot k.
  - Entries consumed by `otake` are not written: `tl` and `count` advance by `iacc - take` and `hd` is unchanged.
  - This creates a combinational path from `inum`/`ibits` to `onum`/`obits`.
- Undefined: always 1-cycle latency, and no combinational path from input to output.

## Structure
- Shared package `types`: add a `localparam` helper function `min_u` (unsigned minimum) and the typedef `qptr_t` pattern via a parametrised width. The payload structs already live there, and callers pass `$bits()` of them.
- One sub-module, `queue_rotator`: an OUT-way mux selecting entries `hd+k` mod DEPTH. It is reused for the write-side demux (`tl+k`).

## Test plan
- Reset, then `inum`=3, payloads A,B,C → `iacc`=3; next cycle `onum`=3, `obits`={C,B,A}, `count`=3.
- DEPTH=16, `count`=14, `inum`=4 → `iacc`=2; the re-offered 2 slots are accepted after `otake`=2 the same cycle, in the following cycle.
- Pointer wrap: `hd`=`tl`=14, enqueue 4, dequeue 4 over two cycles → the order is preserved across entries 15→0, and `count` returns to 0.
- `flush` with `inum`=4 and `otake`=2 while `count`=8 → `iacc`=0; next cycle `count`=0, `onum`=0.
- `otake`=4 while `onum`=2 → only 2 removed, and `count` decreases by 2.
- With `BUNDLE_QUEUE_BYPASS_EN`: empty, `inum`=2, `otake`=1 → same-cycle `onum`=2; next cycle `count`=1 and `obits` slot 0 = second payload.
